// File: rtl/sw_job_scheduler.sv
// Job sequencer in front of the Smith-Waterman engine: queues jobs, drives set-T/start, returns tagged scores.
// Optional watchdog on engine waits is enabled by defining SW_SCHED_TIMEOUT_EN.
module sw_job_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int QUEUE_LOG   = 2,
  parameter int RES_W       = 16,
  parameter int MATCH_W     = 4,
  parameter int TAG_W       = 4,
  parameter int GUARD_CYC   = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_job_valid,
  output logic               o_job_ready,
  input  logic               i_job_set_t,
  input  logic [MATCH_W-1:0] i_job_match,
  input  logic [MATCH_W-1:0] i_job_mismatch,
  input  logic [7:0]         i_job_alpha,
  input  logic [7:0]         i_job_beta,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [RES_W-1:0]   o_res,
  output logic [TAG_W-1:0]   o_res_tag,
  output logic               o_res_err,
  output logic               o_eng_set_t,
  output logic               o_eng_start,
  input  logic               i_eng_busy,
  input  logic [RES_W-1:0]   i_eng_result,
  input  logic               i_eng_valid,
  output logic [MATCH_W-1:0] o_eng_match,
  output logic [MATCH_W-1:0] o_eng_mismatch,
  output logic [7:0]         o_eng_alpha,
  output logic [7:0]         o_eng_beta,
  output logic               o_eng_param_valid,
  output logic               o_t_loaded
);

  typedef struct packed {
    logic               set_t;
    logic [MATCH_W-1:0] match;
    logic [MATCH_W-1:0] mismatch;
    logic [7:0]         alpha;
    logic [7:0]         beta;
    logic [TAG_W-1:0]   tag;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PARAM, S_LOAD_T, S_WAIT_T, S_START, S_CALC, S_WAIT_IDLE, S_REPORT
  } state_t;

  localparam int GW = $clog2(GUARD_CYC + 2);
  localparam logic [GW-1:0]        GUARD_LD  = GW'(GUARD_CYC);
  localparam logic [GW-1:0]        GUARD_ONE = GW'(1);
  localparam logic [QUEUE_LOG:0]   CNT_ONE   = (QUEUE_LOG+1)'(1);
  localparam logic [QUEUE_LOG:0]   CNT_FULL  = (QUEUE_LOG+1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_LOG-1:0] PTR_ONE   = QUEUE_LOG'(1);
  localparam logic [TAG_W-1:0]     TAG_ONE   = TAG_W'(1);

  job_t                 r_mem [QUEUE_DEPTH];
  job_t                 w_entry;
  logic [QUEUE_LOG-1:0] r_wr_ptr, r_rd_ptr;
  logic [QUEUE_LOG:0]   r_count, w_count_next;
  logic                 r_job_ready;
  logic [TAG_W-1:0]     r_tag_cnt;
  logic                 w_push, w_pop;

  state_t               r_state;
  job_t                 r_job;
  logic [GW-1:0]        r_guard;
  logic [RES_W-1:0]     r_cap_res;
  logic                 r_err;
  logic                 r_eng_set_t, r_eng_start, r_param_valid, r_t_loaded;
  logic [MATCH_W-1:0]   r_eng_match, r_eng_mismatch;
  logic [7:0]           r_eng_alpha, r_eng_beta;
  logic                 r_res_valid, r_res_err;
  logic [RES_W-1:0]     r_res;
  logic [TAG_W-1:0]     r_res_tag;
`ifdef SW_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYC - 1);
  logic [15:0]          r_wdog;
`endif

  assign w_entry = {i_job_set_t, i_job_match, i_job_mismatch, i_job_alpha, i_job_beta, r_tag_cnt};
  assign w_push  = i_job_valid & r_job_ready;
  // A held result blocks the next pop unless the host takes it this very cycle.
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0) && (!r_res_valid || i_res_ready);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop)
      w_count_next = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_job_ready <= 1'b1;
      r_tag_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
        r_tag_cnt <= r_tag_cnt + TAG_ONE;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count     <= w_count_next;
      r_job_ready <= (w_count_next != CNT_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_job          <= '0;
      r_guard        <= '0;
      r_cap_res      <= '0;
      r_err          <= 1'b0;
      r_eng_set_t    <= 1'b0;
      r_eng_start    <= 1'b0;
      r_param_valid  <= 1'b0;
      r_t_loaded     <= 1'b0;
      r_eng_match    <= '0;
      r_eng_mismatch <= '0;
      r_eng_alpha    <= '0;
      r_eng_beta     <= '0;
      r_res_valid    <= 1'b0;
      r_res_err      <= 1'b0;
      r_res          <= '0;
      r_res_tag      <= '0;
`ifdef SW_SCHED_TIMEOUT_EN
      r_wdog         <= '0;
`endif
    end else begin
      r_eng_set_t   <= 1'b0;
      r_eng_start   <= 1'b0;
      r_param_valid <= 1'b0;
      if (r_guard != '0)
        r_guard <= r_guard - GUARD_ONE;
      if (r_res_valid && i_res_ready)
        r_res_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_job   <= r_mem[r_rd_ptr];
            r_state <= S_PARAM;
          end
        end
        S_PARAM: begin
          r_eng_match    <= r_job.match;
          r_eng_mismatch <= r_job.mismatch;
          r_eng_alpha    <= r_job.alpha;
          r_eng_beta     <= r_job.beta;
          r_param_valid  <= 1'b1;
          r_guard        <= '0;
          if (r_job.set_t)
            r_state <= S_LOAD_T;
          else if (!r_t_loaded) begin
            r_err     <= 1'b1;
            r_cap_res <= '0;
            r_state   <= S_REPORT;
          end else
            r_state <= S_START;
        end
        S_LOAD_T: begin
          r_eng_set_t <= 1'b1;
          r_guard     <= GUARD_LD;
          r_state     <= S_WAIT_T;
`ifdef SW_SCHED_TIMEOUT_EN
          r_wdog      <= '0;
`endif
        end
        S_WAIT_T: begin
          // Busy from the engine lags the pulse, so it is trusted only after the guard.
          if (r_guard == '0 && !i_eng_busy) begin
            r_t_loaded <= 1'b1;
            r_state    <= S_START;
          end
`ifdef SW_SCHED_TIMEOUT_EN
          else if (r_wdog == WD_LIM) begin
            r_t_loaded <= 1'b0;
            r_err      <= 1'b1;
            r_cap_res  <= '0;
            r_state    <= S_REPORT;
          end else
            r_wdog <= r_wdog + 16'd1;
`endif
        end
        S_START: begin
          r_eng_start <= 1'b1;
          r_guard     <= GUARD_LD;
          r_err       <= 1'b0;
          r_state     <= S_CALC;
`ifdef SW_SCHED_TIMEOUT_EN
          r_wdog      <= '0;
`endif
        end
        S_CALC: begin
          if (i_eng_valid) begin
            r_cap_res <= i_eng_result;
            r_state   <= S_WAIT_IDLE;
          end
`ifdef SW_SCHED_TIMEOUT_EN
          else if (r_wdog == WD_LIM) begin
            r_err     <= 1'b1;
            r_cap_res <= '0;
            r_state   <= S_REPORT;
          end else
            r_wdog <= r_wdog + 16'd1;
`endif
        end
        S_WAIT_IDLE: begin
          if (r_guard == '0 && !i_eng_busy)
            r_state <= S_REPORT;
        end
        S_REPORT: begin
          r_res_valid <= 1'b1;
          r_res       <= r_cap_res;
          r_res_tag   <= r_job.tag;
          r_res_err   <= r_err;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_job_ready       = r_job_ready;
  assign o_res_valid       = r_res_valid;
  assign o_res             = r_res;
  assign o_res_tag         = r_res_tag;
  assign o_res_err         = r_res_err;
  assign o_eng_set_t       = r_eng_set_t;
  assign o_eng_start       = r_eng_start;
  assign o_eng_match       = r_eng_match;
  assign o_eng_mismatch    = r_eng_mismatch;
  assign o_eng_alpha       = r_eng_alpha;
  assign o_eng_beta        = r_eng_beta;
  assign o_eng_param_valid = r_param_valid;
  assign o_t_loaded        = r_t_loaded;

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Directed bench for sw_job_scheduler; the engine side is driven by hand in each step.
module tb_sw_job_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_job_valid = 1'b0;
  logic        o_job_ready;
  logic        i_job_set_t = 1'b0;
  logic [3:0]  i_job_match = '0;
  logic [3:0]  i_job_mismatch = '0;
  logic [7:0]  i_job_alpha = '0;
  logic [7:0]  i_job_beta = '0;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [15:0] o_res;
  logic [3:0]  o_res_tag;
  logic        o_res_err;
  logic        o_eng_set_t;
  logic        o_eng_start;
  logic        i_eng_busy = 1'b0;
  logic [15:0] i_eng_result = '0;
  logic        i_eng_valid = 1'b0;
  logic [3:0]  o_eng_match;
  logic [3:0]  o_eng_mismatch;
  logic [7:0]  o_eng_alpha;
  logic [7:0]  o_eng_beta;
  logic        o_eng_param_valid;
  logic        o_t_loaded;

  int n_total = 0;
  int n_pass  = 0;
  int n_sett  = 0;
  int n_start = 0;
  int n_both  = 0;

  sw_job_scheduler #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_set_t(i_job_set_t), .i_job_match(i_job_match), .i_job_mismatch(i_job_mismatch),
    .i_job_alpha(i_job_alpha), .i_job_beta(i_job_beta),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res(o_res),
    .o_res_tag(o_res_tag), .o_res_err(o_res_err),
    .o_eng_set_t(o_eng_set_t), .o_eng_start(o_eng_start), .i_eng_busy(i_eng_busy),
    .i_eng_result(i_eng_result), .i_eng_valid(i_eng_valid),
    .o_eng_match(o_eng_match), .o_eng_mismatch(o_eng_mismatch),
    .o_eng_alpha(o_eng_alpha), .o_eng_beta(o_eng_beta),
    .o_eng_param_valid(o_eng_param_valid), .o_t_loaded(o_t_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_eng_set_t) n_sett++;
    if (o_eng_start) n_start++;
    if (o_eng_set_t && o_eng_start) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return o_eng_set_t;
      1:       return o_eng_start;
      default: return o_res_valid;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int max_cyc, input string tag, output int cyc);
    cyc = 0;
    while (sel(which) !== 1'b1 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    check(tag, 32'(sel(which)), 1);
  endtask

  task automatic set_job(input logic st, input logic [3:0] m, input logic [3:0] mm,
                         input logic [7:0] a, input logic [7:0] b);
    i_job_set_t = st; i_job_match = m; i_job_mismatch = mm; i_job_alpha = a; i_job_beta = b;
  endtask

  task automatic push(input logic st, input logic [3:0] m, input logic [3:0] mm,
                      input logic [7:0] a, input logic [7:0] b);
    set_job(st, m, mm, a, b);
    i_job_valid = 1'b1;
    tick();
    i_job_valid = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] res);
    i_eng_result = res;
    i_eng_valid  = 1'b1;
    tick();
    i_eng_valid  = 1'b0;
  endtask

  task automatic consume();
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
  endtask

  task automatic run_job(input logic st, input logic [15:0] res, input int exp_tag);
    int c;
    push(st, 4'd2, 4'd1, 8'd3, 8'd1);
    if (st) wait_sig(0, 10, "rj_set_t", c);
    wait_sig(1, 30, "rj_start", c);
    tick();
    strobe(res);
    wait_sig(2, 20, "rj_res_valid", c);
    check("rj_res", 32'(o_res), 32'(res));
    check("rj_tag", 32'(o_res_tag), 32'(exp_tag % 16));
    check("rj_err", 32'(o_res_err), 0);
    consume();
  endtask

  initial begin
    int cyc;
    int base_s, base_t;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_job_ready", 32'(o_job_ready), 1);
    check("rst_res_valid", 32'(o_res_valid), 0);
    check("rst_t_loaded",  32'(o_t_loaded), 0);
    check("rst_start",     32'(o_eng_start), 0);

    // Job with T load, engine busy for 10 cycles after set_t
    base_s = n_start; base_t = n_sett;
    push(1'b1, 4'd2, 4'd1, 8'd3, 8'd1);
    wait_sig(0, 10, "t1_set_t", cyc);
    check("t1_match", 32'(o_eng_match), 2);
    check("t1_alpha", 32'(o_eng_alpha), 3);
    i_eng_busy = 1'b1;
    repeat (10) tick();
    check("t1_no_early_start", 32'(n_start - base_s), 0);
    i_eng_busy = 1'b0;
    wait_sig(1, 10, "t1_start", cyc);
    i_eng_busy = 1'b1;
    repeat (3) tick();
    i_eng_busy = 1'b0;
    strobe(16'h0012);
    wait_sig(2, 20, "t1_res_valid", cyc);
    check("t1_res", 32'(o_res), 32'h12);
    check("t1_tag", 32'(o_res_tag), 0);
    check("t1_err", 32'(o_res_err), 0);
    check("t1_t_loaded", 32'(o_t_loaded), 1);
    consume();
    check("t1_set_t_count", 32'(n_sett - base_t), 1);
    check("t1_start_count", 32'(n_start - base_s), 1);

    // Two queued jobs; first result held 20 cycles
    i_job_valid = 1'b1;
    set_job(1'b0, 4'd5, 4'd2, 8'd4, 8'd2);
    tick();
    set_job(1'b0, 4'd6, 4'd1, 8'd5, 8'd3);
    tick();
    i_job_valid = 1'b0;
    wait_sig(1, 10, "t2_start1", cyc);
    check("t2_lat1", 32'(cyc), 2);
    check("t2_match1", 32'(o_eng_match), 5);
    tick(); tick();
    strobe(16'h0034);
    wait_sig(2, 20, "t2_res1_valid", cyc);
    check("t2_res1", 32'(o_res), 32'h34);
    check("t2_tag1", 32'(o_res_tag), 1);
    base_s = n_start;
    repeat (20) tick();
    check("t2_hold_no_start", 32'(n_start - base_s), 0);
    check("t2_hold_valid", 32'(o_res_valid), 1);
    check("t2_hold_res", 32'(o_res), 32'h34);
    consume();
    check("t2_taken", 32'(o_res_valid), 0);
    wait_sig(1, 10, "t2_start2", cyc);
    check("t2_lat2", 32'(cyc), 2);
    check("t2_match2", 32'(o_eng_match), 6);
    tick();
    strobe(16'h0056);
    wait_sig(2, 20, "t2_res2_valid", cyc);
    check("t2_res2", 32'(o_res), 32'h56);
    check("t2_tag2", 32'(o_res_tag), 2);
    consume();

    // Fill the FIFO while the engine holds job 3 in calculation
    push(1'b0, 4'd1, 4'd1, 8'd1, 8'd1);
    wait_sig(1, 10, "t4_start0", cyc);
    set_job(1'b0, 4'd0, 4'd1, 8'd2, 8'd2);
    i_job_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_job_match = 4'(k);
      tick();
      check("t4_ready", 32'(o_job_ready), (k < 3) ? 1 : 0);
    end
    i_job_match = 4'd9;
    tick(); tick();
    check("t4_refused", 32'(o_job_ready), 0);
    strobe(16'h0077);
    wait_sig(2, 20, "t4_res0_valid", cyc);
    check("t4_res0", 32'(o_res), 32'h77);
    check("t4_tag0", 32'(o_res_tag), 3);
    consume();
    check("t4_ready_after_pop", 32'(o_job_ready), 1);
    tick();
    i_job_valid = 1'b0;
    check("t4_full_again", 32'(o_job_ready), 0);
    for (int k = 0; k < 5; k++) begin
      wait_sig(1, 20, "t4_start", cyc);
      tick();
      strobe(16'(32'h20 + k));
      wait_sig(2, 20, "t4_res_valid", cyc);
      check("t4_tag", 32'(o_res_tag), 32'(4 + k));
      check("t4_res", 32'(o_res), 32'h20 + 32'(k));
      consume();
    end

    // Tag wrap 15 -> 0
    for (int k = 0; k < 9; k++)
      run_job(1'b0, 16'(32'h100 + k), 9 + k);

    // Reset during CALC with jobs still queued
    push(1'b0, 4'd3, 4'd3, 8'd3, 8'd3);
    wait_sig(1, 10, "t5_start", cyc);
    push(1'b0, 4'd4, 4'd4, 8'd4, 8'd4);
    push(1'b0, 4'd5, 4'd5, 8'd5, 8'd5);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(o_job_ready), 1);
    check("t5_rst_t_loaded", 32'(o_t_loaded), 0);
    check("t5_rst_alpha", 32'(o_eng_alpha), 0);
    check("t5_rst_res_valid", 32'(o_res_valid), 0);
    tick();
    rst = 1'b0;
    base_s = n_start; base_t = n_sett;
    repeat (6) tick();
    check("t5_fifo_empty", 32'(n_start - base_s), 0);
    check("t5_no_result", 32'(o_res_valid), 0);

    // After reset: no T loaded, set_t=0 job reports an error
    push(1'b0, 4'd7, 4'd3, 8'd9, 8'd5);
    wait_sig(2, 10, "t3_res_valid", cyc);
    check("t3_err", 32'(o_res_err), 1);
    check("t3_res", 32'(o_res), 0);
    check("t3_tag", 32'(o_res_tag), 0);
    check("t3_match", 32'(o_eng_match), 7);
    check("t3_alpha", 32'(o_eng_alpha), 9);
    consume();
    check("t3_no_set_t", 32'(n_sett - base_t), 0);
    check("t3_no_start", 32'(n_start - base_s), 0);
    run_job(1'b1, 16'h0099, 1);
    check("t3_t_loaded", 32'(o_t_loaded), 1);

`ifdef SW_SCHED_TIMEOUT_EN
    // Engine never answers: watchdog reports an error after 100 CALC cycles
    push(1'b0, 4'd1, 4'd1, 8'd1, 8'd1);
    wait_sig(1, 10, "to_start", cyc);
    wait_sig(2, 200, "to_res_valid", cyc);
    check("to_cycles", 32'(cyc), 101);
    check("to_err", 32'(o_res_err), 1);
    check("to_res", 32'(o_res), 0);
    consume();
    run_job(1'b0, 16'h00aa, 3);
`endif

    check("no_set_t_start_overlap", 32'(n_both), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
